// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported backing memory between the instruction-fetch (I)
// and data (D) requesters. One transaction in flight at a time; D has priority, but a streak
// cap forces I through after D_STREAK_MAX consecutive D grants with I pending. A watchdog
// aborts any transaction whose memory response never arrives and answers it with data 0.
module mem_port_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned D_STREAK_MAX = 4,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic            clk,
  input  logic            reset,
  // Fetch requester
  input  logic            i_req_valid,
  input  logic [XLEN-1:0] i_req_addr,
  output logic            i_res_valid,
  output logic [XLEN-1:0] i_res_data,
  // Data requester
  input  logic            d_req_valid,
  input  logic [XLEN-1:0] d_req_addr,
  input  logic            d_req_fcn,
  input  logic [2:0]      d_req_typ,
  input  logic [XLEN-1:0] d_req_wdata,
  output logic            d_res_valid,
  output logic [XLEN-1:0] d_res_data,
  // Memory side
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  output logic            mem_req_fcn,
  output logic [2:0]      mem_req_typ,
  output logic [XLEN-1:0] mem_req_wdata,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  // Status
  output logic            err_timeout,
  output logic            grant_d
);

  localparam int unsigned      WdogW     = $clog2(TIMEOUT + 1);
  localparam logic             MXrd      = 1'b0;
  localparam logic [2:0]       MtWu      = 3'd7;
  localparam logic [3:0]       StreakMax = 4'(D_STREAK_MAX);
  localparam logic [WdogW-1:0] WdogLast  = WdogW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e           state_q;
  logic [3:0]       streak_q;
  logic [WdogW-1:0] wdog_q;

  logic done;    // owner's response completes this cycle
  logic abort;   // watchdog expires this cycle without a response
  logic arb_en;
  logic d_cand;
  logic i_cand;
  logic pick_d;
  logic pick_i;

  // Per-cycle completion, abort and arbitration decisions
  always_comb begin
    unique case (state_q)
      StReq:   done = mem_req_ready & mem_resp_valid;
      StWait:  done = mem_resp_valid;
      default: done = 1'b0;
    endcase
    abort  = (state_q != StIdle) && !done && (wdog_q == WdogLast);
    arb_en = (state_q == StIdle) || done;
    // The completing requester still holds its old request high this cycle, so mask it.
    d_cand = d_req_valid && !(done && grant_d);
    i_cand = i_req_valid && !(done && !grant_d);
    pick_d = arb_en && d_cand && !(i_cand && (streak_q == StreakMax));
    pick_i = arb_en && i_cand && !pick_d;
  end

  // Transaction FSM with registered request/response outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      streak_q      <= '0;
      wdog_q        <= '0;
      i_res_valid   <= 1'b0;
      i_res_data    <= '0;
      d_res_valid   <= 1'b0;
      d_res_data    <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_fcn   <= 1'b0;
      mem_req_typ   <= '0;
      mem_req_wdata <= '0;
      err_timeout   <= 1'b0;
      grant_d       <= 1'b0;
    end else begin
      i_res_valid <= 1'b0;
      d_res_valid <= 1'b0;
      if (state_q != StIdle) begin
        wdog_q <= wdog_q + 1'b1;
      end

      unique case (state_q)
        StIdle: ;
        StReq: begin
          if (mem_req_ready) begin
            state_q       <= StWait;
            mem_req_valid <= 1'b0;
          end
        end
        StWait: ;
        default: state_q <= StIdle;
      endcase

      // End of transaction: normal response or watchdog abort (data forced to 0)
      if (done || abort) begin
        if (grant_d) begin
          d_res_valid <= 1'b1;
          d_res_data  <= done ? mem_resp_data : '0;
        end else begin
          i_res_valid <= 1'b1;
          i_res_data  <= done ? mem_resp_data : '0;
        end
        state_q       <= StIdle;
        mem_req_valid <= 1'b0;
      end
      if (abort) begin
        err_timeout <= 1'b1;
      end

      // New grant overrides the return to idle, giving back-to-back issue
      if (pick_d) begin
        state_q       <= StReq;
        mem_req_valid <= 1'b1;
        grant_d       <= 1'b1;
        mem_req_addr  <= d_req_addr;
        mem_req_fcn   <= d_req_fcn;
        mem_req_typ   <= d_req_typ;
        mem_req_wdata <= d_req_wdata;
        wdog_q        <= '0;
        if (i_req_valid && (streak_q != StreakMax)) begin
          streak_q <= streak_q + 4'd1;
        end
      end else if (pick_i) begin
        state_q       <= StReq;
        mem_req_valid <= 1'b1;
        grant_d       <= 1'b0;
        mem_req_addr  <= i_req_addr;
        mem_req_fcn   <= MXrd;
        mem_req_typ   <= MtWu;
        mem_req_wdata <= '0;
        wdog_q        <= '0;
        streak_q      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a small reactive memory model.
module tb_mem_port_arbiter;

  localparam int unsigned XLEN = 32;

  logic            clk;
  logic            reset;
  logic            i_req_valid;
  logic [XLEN-1:0] i_req_addr;
  logic            i_res_valid;
  logic [XLEN-1:0] i_res_data;
  logic            d_req_valid;
  logic [XLEN-1:0] d_req_addr;
  logic            d_req_fcn;
  logic [2:0]      d_req_typ;
  logic [XLEN-1:0] d_req_wdata;
  logic            d_res_valid;
  logic [XLEN-1:0] d_res_data;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_req_fcn;
  logic [2:0]      mem_req_typ;
  logic [XLEN-1:0] mem_req_wdata;
  logic            mem_resp_valid;
  logic [XLEN-1:0] mem_resp_data;
  logic            err_timeout;
  logic            grant_d;

  mem_port_arbiter #(
    .XLEN         (XLEN),
    .D_STREAK_MAX (4),
    .TIMEOUT      (8)
  ) u_dut (
    .clk            (clk),
    .reset          (reset),
    .i_req_valid    (i_req_valid),
    .i_req_addr     (i_req_addr),
    .i_res_valid    (i_res_valid),
    .i_res_data     (i_res_data),
    .d_req_valid    (d_req_valid),
    .d_req_addr     (d_req_addr),
    .d_req_fcn      (d_req_fcn),
    .d_req_typ      (d_req_typ),
    .d_req_wdata    (d_req_wdata),
    .d_res_valid    (d_res_valid),
    .d_res_data     (d_res_data),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_fcn    (mem_req_fcn),
    .mem_req_typ    (mem_req_typ),
    .mem_req_wdata  (mem_req_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .err_timeout    (err_timeout),
    .grant_d        (grant_d)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory model knobs, written only by the stimulus process
  int ready_hold  = 0;   // cycles of mem_req_ready low before accepting
  int resp_lat    = 2;   // cycles from accept to mem_resp_valid (>= 1)
  bit resp_en_i   = 1'b1;
  bit resp_en_d   = 1'b1;
  bit inject_resp = 1'b0;
  bit mem_flush   = 1'b0;

  // Memory model state and logs, written only by the memory process
  int          wcnt     = 0;
  int          pend     = 0;
  logic [31:0] pend_data;
  int          accepts  = 0;
  logic        grant_log[$];

  int i_pulses = 0;
  int d_pulses = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr == 32'h100) ? 32'h0000_0013 : addr + 32'h1000_0000;
  endfunction

  // Reactive memory: drives ready/response at the falling edge
  initial begin
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    pend_data      = '0;
    forever begin
      @(negedge clk);
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      if (mem_flush) begin
        pend = 0;
        wcnt = 0;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = pend_data;
        end
      end
      if (inject_resp) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hBAD0_BAD0;
      end
      if (mem_req_valid) begin
        if (wcnt >= ready_hold) begin
          mem_req_ready = 1'b1;
          wcnt = 0;
          accepts++;
          grant_log.push_back(grant_d);
          if (grant_d ? resp_en_d : resp_en_i) begin
            pend      = resp_lat;
            pend_data = mem_word(mem_req_addr);
          end
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Response pulse counters
  initial begin
    forever begin
      @(negedge clk);
      if (i_res_valid) i_pulses++;
      if (d_res_valid) d_pulses++;
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not reach its end");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_req_valid = 1'b0;
    i_req_addr  = '0;
    d_req_valid = 1'b0;
    d_req_addr  = '0;
    d_req_fcn   = 1'b0;
    d_req_typ   = '0;
    d_req_wdata = '0;
    inject_resp = 1'b0;
    mem_flush   = 1'b1;
    reset       = 1'b1;
    tick();
    tick();
    reset     = 1'b0;
    mem_flush = 1'b0;
    tick();
  endtask

  // Waits for the requester's response pulse, then drops its request like the core would
  task automatic wait_res(input bit is_d, input int budget, output int lat);
    lat = -1;
    for (int n = 1; n <= budget; n++) begin
      tick();
      if (is_d ? d_res_valid : i_res_valid) begin
        lat = n;
        if (is_d) d_req_valid = 1'b0;
        else      i_req_valid = 1'b0;
        break;
      end
    end
  endtask

  bit exp_order[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    int   lat;
    int   p_i0;
    int   p_d0;
    int   acc0;
    int   base;
    logic seen;
    logic g;

    reset = 1'b1;
    do_reset();

    // Reset state
    check_val("rst_mem_req_valid", mem_req_valid, 32'd0);
    check_val("rst_i_res_valid", i_res_valid, 32'd0);
    check_val("rst_d_res_valid", d_res_valid, 32'd0);
    check_val("rst_err_timeout", err_timeout, 32'd0);
    check_val("rst_grant_d", grant_d, 32'd0);
    check_val("rst_mem_req_addr", mem_req_addr, 32'd0);

    // Single fetch
    p_i0 = i_pulses;
    p_d0 = d_pulses;
    i_req_addr  = 32'h100;
    i_req_valid = 1'b1;
    tick();
    check_val("fetch_req_valid", mem_req_valid, 32'd1);
    check_val("fetch_req_addr", mem_req_addr, 32'h100);
    check_val("fetch_req_typ", mem_req_typ, 32'd7);
    check_val("fetch_req_fcn", mem_req_fcn, 32'd0);
    check_val("fetch_grant_d", grant_d, 32'd0);
    wait_res(1'b0, 10, lat);
    check_val("fetch_latency", lat, 32'd3);
    check_val("fetch_res_data", i_res_data, 32'h13);
    tick();
    check_val("fetch_pulse_width", i_res_valid, 32'd0);
    check_val("fetch_i_pulses", i_pulses - p_i0, 32'd1);
    check_val("fetch_d_pulses", d_pulses - p_d0, 32'd0);

    // Simultaneous I and D: D store first, I issued back-to-back
    do_reset();
    d_req_addr  = 32'h2000;
    d_req_fcn   = 1'b1;
    d_req_typ   = 3'd3;
    d_req_wdata = 32'hDEAD_BEEF;
    d_req_valid = 1'b1;
    i_req_addr  = 32'h104;
    i_req_valid = 1'b1;
    tick();
    check_val("simul_grant_d", grant_d, 32'd1);
    check_val("simul_req_valid", mem_req_valid, 32'd1);
    check_val("simul_req_fcn", mem_req_fcn, 32'd1);
    check_val("simul_req_addr", mem_req_addr, 32'h2000);
    check_val("simul_req_wdata", mem_req_wdata, 32'hDEAD_BEEF);
    check_val("simul_req_typ", mem_req_typ, 32'd3);
    wait_res(1'b1, 10, lat);
    check_val("simul_d_latency", lat, 32'd3);
    check_val("simul_d_res_data", d_res_data, 32'h1000_2000);
    check_val("b2b_req_valid", mem_req_valid, 32'd1);
    check_val("b2b_grant_d", grant_d, 32'd0);
    check_val("b2b_req_addr", mem_req_addr, 32'h104);
    check_val("b2b_req_fcn", mem_req_fcn, 32'd0);
    check_val("b2b_req_typ", mem_req_typ, 32'd7);
    check_val("b2b_req_wdata", mem_req_wdata, 32'd0);
    check_val("b2b_i_res_quiet", i_res_valid, 32'd0);
    wait_res(1'b0, 10, lat);
    check_val("b2b_i_latency", lat, 32'd3);
    check_val("b2b_i_res_data", i_res_data, 32'h1000_0104);

    // Backpressure: ready low for 5 cycles
    do_reset();
    ready_hold = 5;
    resp_lat   = 1;
    acc0 = accepts;
    i_req_addr  = 32'h300;
    i_req_valid = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      check_val($sformatf("bp_valid_c%0d", c), mem_req_valid, 32'd1);
      check_val($sformatf("bp_addr_c%0d", c), mem_req_addr, 32'h300);
      check_val($sformatf("bp_typ_c%0d", c), mem_req_typ, 32'd7);
    end
    wait_res(1'b0, 10, lat);
    check_val("bp_latency", lat, 32'd3);
    check_val("bp_res_data", i_res_data, 32'h1000_0300);
    check_val("bp_accept_count", accepts - acc0, 32'd1);
    ready_hold = 0;
    resp_lat   = 2;

    // Timeout: D load whose response never arrives
    do_reset();
    resp_en_d = 1'b0;
    p_i0 = i_pulses;
    p_d0 = d_pulses;
    d_req_addr  = 32'h40;
    d_req_fcn   = 1'b0;
    d_req_typ   = 3'd3;
    d_req_valid = 1'b1;
    wait_res(1'b1, 20, lat);
    check_val("to_latency", lat, 32'd9);
    check_val("to_res_data", d_res_data, 32'd0);
    check_val("to_err_timeout", err_timeout, 32'd1);
    tick();
    inject_resp = 1'b1;
    tick();
    inject_resp = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      seen = seen | i_res_valid | d_res_valid | mem_req_valid;
    end
    check_val("to_late_resp_dropped", seen, 32'd0);
    check_val("to_err_sticky", err_timeout, 32'd1);
    check_val("to_d_pulses", d_pulses - p_d0, 32'd1);
    check_val("to_i_pulses", i_pulses - p_i0, 32'd0);
    resp_en_d = 1'b1;

    // Starvation: D and I always valid. A level-held I would win every back-to-back slot
    // after a completed D, so D transactions are left unanswered and end by watchdog,
    // returning through idle where the streak cap decides.
    do_reset();
    resp_en_d = 1'b0;
    base = grant_log.size();
    d_req_addr  = 32'h500;
    d_req_fcn   = 1'b0;
    d_req_typ   = 3'd3;
    d_req_valid = 1'b1;
    i_req_addr  = 32'h600;
    i_req_valid = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if (grant_log.size() - base >= 10) break;
      tick();
    end
    check_val("starve_grant_count", (grant_log.size() - base) >= 10, 32'd1);
    for (int j = 0; j < 10; j++) begin
      g = (base + j < grant_log.size()) ? grant_log[base + j] : 1'bx;
      check_val($sformatf("starve_grant%0d", j), g, exp_order[j]);
    end
    d_req_valid = 1'b0;
    i_req_valid = 1'b0;
    resp_en_d   = 1'b1;

    // Reset during WAIT, memory response arrives afterwards
    do_reset();
    resp_lat = 4;
    p_i0 = i_pulses;
    p_d0 = d_pulses;
    i_req_addr  = 32'h700;
    i_req_valid = 1'b1;
    tick();
    tick();
    check_val("rw_in_wait", mem_req_valid, 32'd0);
    reset       = 1'b1;
    i_req_valid = 1'b0;
    #1;
    check_val("rw_async_req_valid", mem_req_valid, 32'd0);
    check_val("rw_async_req_addr", mem_req_addr, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    seen  = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      seen = seen | i_res_valid | d_res_valid;
    end
    check_val("rw_no_res", seen, 32'd0);
    check_val("rw_pulses", (i_pulses - p_i0) + (d_pulses - p_d0), 32'd0);
    check_val("rw_req_valid", mem_req_valid, 32'd0);
    check_val("rw_grant_d", grant_d, 32'd0);
    check_val("rw_err", err_timeout, 32'd0);
    check_val("rw_i_res_data", i_res_data, 32'd0);
    resp_lat    = 2;
    i_req_addr  = 32'h704;
    i_req_valid = 1'b1;
    wait_res(1'b0, 10, lat);
    check_val("rw_next_latency", lat, 32'd4);
    check_val("rw_next_data", i_res_data, 32'h1000_0704);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported backing memory between the instruction-fetch requester (I) and the data requester (D) of the 5-stage core.
- Holds at most one transaction in flight. D has priority over I, with a streak limit so fetch is never starved.
- A watchdog counter ends any transaction whose memory response never arrives, returning an error response.
- Sits between the control/data paths (imem_in/imem_out, dmem_in/dmem_out bundles) and the memory model or bus.

Parameters:
- XLEN, 32, address/data width.
- D_STREAK_MAX, 4, max consecutive D grants while I is pending before I is forced (range 1..15).
- TIMEOUT, 64, cycles waiting for mem_resp_valid before abort (range 2..255).

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- i_req_valid  in  1  fetch request; held until i_res_valid
- i_req_addr  in  XLEN  fetch address
- i_res_valid  out  1  fetch response strobe, 1 cycle
- i_res_data  out  XLEN  fetch data
- d_req_valid  in  1  data request; held until d_res_valid
- d_req_addr  in  XLEN  data address
- d_req_fcn  in  1  0=M_XRD, 1=M_XWR
- d_req_typ  in  3  memory mask type (MT_B..MT_WU encoding)
- d_req_wdata  in  XLEN  store data
- d_res_valid  out  1  data response strobe, 1 cycle
- d_res_data  out  XLEN  load data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  XLEN  address
- mem_req_fcn  out  1  function
- mem_req_typ  out  3  mask type
- mem_req_wdata  out  XLEN  store data
- mem_resp_valid  in  1  memory response, 1 cycle
- mem_resp_data  in  XLEN  response data
- err_timeout  out  1  sticky; set on any abort, cleared only by reset
- grant_d  out  1  owner of the current or last transaction (1=D, 0=I)

Behaviour:
- States: IDLE, REQ (mem_req_valid=1, waiting for mem_req_ready), WAIT (waiting for mem_resp_valid).
- Reset (async) values:
  - Outputs: state=IDLE, all *_valid outputs 0, data/addr outputs 0, err_timeout=0, grant_d=0.
  - Internal: streak counter=0, watchdog=0.
- Arbitration:
  - Evaluated in IDLE, and in the cycle a response completes (back-to-back).
  - D wins if d_req_valid, unless i_req_valid and streak==D_STREAK_MAX; in that case I wins.
  - Otherwise I wins if i_req_valid. With neither valid, the state stays IDLE.
- Grant action: latch addr/fcn/typ/wdata of the winner into output registers, set grant_d, go to REQ.
  - mem_req_valid is asserted the cycle after the grant decision, so request-to-memory latency is 1 cycle.
  - I requests are driven with fcn=M_XRD, typ=MT_WU, wdata=0.
- Streak counter:
  - D grant while i_req_valid: streak+1, saturating at D_STREAK_MAX.
  - Any I grant: streak=0.
  - D grant while I idle: streak unchanged.
- REQ: mem_req_valid held with stable fields until mem_req_ready; then go to WAIT, and mem_req_valid=0 next cycle.
  - If mem_resp_valid arrives in the same cycle as mem_req_ready (zero-latency memory), complete immediately as in WAIT.
- WAIT: on mem_resp_valid, pulse the owner's *_res_valid for exactly 1 cycle (registered, 1 cycle after mem_resp_valid), with *_res_data=mem_resp_data.
  - For stores, d_res_data=mem_resp_data, don't-care for the core.
  - The other requester's res_valid stays 0.
- Back-to-back:
  - In the mem_resp_valid cycle, re-arbitrate. The completing requester's req_valid is ignored for that one cycle, because it is still held high.
  - The new winner's mem_req_valid is asserted in the same cycle as the old res_valid pulse. No idle bubble is required beyond this.
- Watchdog:
  - Cleared on entry to REQ; increments each cycle in REQ or WAIT.
  - Reaching TIMEOUT with no completion: pulse the owner's res_valid with data 0, set err_timeout, go to IDLE.
  - A mem_resp_valid arriving later while in IDLE is dropped.
- Requests arriving mid-transaction are not acknowledged; they wait, level-held.
- A requester dropping req_valid after grant does not cancel the transaction; the response is still pulsed.
- Reset asserted mid-transaction: immediate return to IDLE, no response pulse, any in-flight memory response discarded.
- Width: all data paths are XLEN; counters are ceil(log2(TIMEOUT+1)) and 4 bits.

Test Plan:
- Single fetch:
  - Stimulus: i_req_valid, addr 0x100; mem ready at once, resp 2 cycles later with data 0x00000013.
  - Required: mem_req_addr=0x100, typ=MT_WU; i_res_valid for 1 cycle with 0x13; d_res_valid stays 0.
- Simultaneous I and D:
  - Stimulus: both valid, D is a store to 0x2000 with wdata 0xDEADBEEF, typ MT_W.
  - Required: D granted first (grant_d=1, mem_req_fcn=1); I granted back-to-back in the d_res_valid cycle.
- Starvation, D_STREAK_MAX=4:
  - Stimulus: D and I continuously valid.
  - Required: grant order D,D,D,D,I,D,D,D,D,I.
- Backpressure:
  - Stimulus: mem_req_ready held low for 5 cycles.
  - Required: mem_req_valid and all fields stable for 5 cycles; single transaction issued after ready.
- Timeout, TIMEOUT=8:
  - Stimulus: mem_resp_valid never arrives.
  - Required: res_valid with data 0 pulses 8 cycles after entry to REQ; err_timeout=1 thereafter; a late mem_resp_valid is ignored.
- Reset in WAIT:
  - Stimulus: assert reset during WAIT, then mem_resp_valid.
  - Required: no res_valid; all outputs 0; the next request is serviced normally.
